// File: rtl/awg_seg_sequencer.sv
// awg_seg_sequencer
//   Per-channel AWG playback sequencer. A trigger in IDLE snapshots the three
//   DELAY/LEN/ADDR triplets into shadow registers, then plays them in order:
//   each segment waits DELAYn cycles and then issues LENn consecutive reads
//   of the sample RAM starting at ADDRn. The address wraps modulo 2^P_W.
//   All outputs come from flops that register the state of the previous
//   cycle, so the first read appears DELAY1+2 cycles after the trigger edge.
//   I_stop aborts from any state without a done pulse.
//
//   Build option AWG_SEQ_LOOP_EN: after segment 3 the sequencer wraps back to
//   segment 1 using the same shadow values and keeps going until I_stop. A
//   pass in which every segment has zero length finishes normally instead.
//   With the macro undefined, each trigger plays a single pass.
module awg_seg_sequencer #(
    parameter int P_W    = 24,
    parameter int P_NSEG = 3
) (
    input  logic           I_clk,
    input  logic           I_rst,
    input  logic           I_trig,
    input  logic           I_stop,
    input  logic [P_W-1:0] I_delay1,
    input  logic [P_W-1:0] I_delay2,
    input  logic [P_W-1:0] I_delay3,
    input  logic [P_W-1:0] I_len1,
    input  logic [P_W-1:0] I_len2,
    input  logic [P_W-1:0] I_len3,
    input  logic [P_W-1:0] I_addr1,
    input  logic [P_W-1:0] I_addr2,
    input  logic [P_W-1:0] I_addr3,
    output logic           O_rd_en,
    output logic [P_W-1:0] O_rd_addr,
    output logic [1:0]     O_seg,
    output logic           O_busy,
    output logic           O_done
);

    localparam logic [1:0]     LP_SEG_NONE  = 2'd0;
    localparam logic [1:0]     LP_SEG_FIRST = 2'd1;
    localparam logic [1:0]     LP_SEG_LAST  = 2'(P_NSEG);
    localparam logic [P_W-1:0] LP_ZERO      = {P_W{1'b0}};
    localparam logic [P_W-1:0] LP_ONE       = P_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_PLAY  = 2'd2
    } state_t;

    // sequencing state
    state_t         state_q;
    logic [1:0]     seg_q;       // active segment 1..3, 0 in IDLE
    logic [P_W-1:0] cnt_q;       // remaining wait cycles in DELAY
    logic [P_W-1:0] rem_q;       // reads still to issue in PLAY
    logic [P_W-1:0] addr_q;      // next address to issue in PLAY
    logic           fin_q;       // sequence completed in the previous step

`ifdef AWG_SEQ_LOOP_EN
    logic           played_q;    // at least one read issued in this pass
`endif

    // shadow copies of the channel registers, index 0..2 = segment 1..3
    logic [P_W-1:0] dly_sh_q  [3];
    logic [P_W-1:0] len_sh_q  [3];
    logic [P_W-1:0] addr_sh_q [3];

    // registered outputs
    logic           rd_en_q;
    logic [P_W-1:0] rd_addr_q;
    logic [1:0]     seg_o_q;
    logic           busy_q;
    logic           done_q;

    // decode of the current segment and its successor
    logic [P_W-1:0] sel_len_d;
    logic [P_W-1:0] sel_addr_d;
    logic [P_W-1:0] nxt_cnt_d;
    logic [1:0]     nxt_seg_d;
    logic           wrap_ok_d;
    logic           seg_end_d;
    logic           finish_d;

    // Pick the current segment's shadow fields and work out where the sequence goes when it ends
    always_comb begin
        sel_len_d  = len_sh_q[0];
        sel_addr_d = addr_sh_q[0];
        nxt_cnt_d  = dly_sh_q[1];
        case (seg_q)
            2'd2: begin
                sel_len_d  = len_sh_q[1];
                sel_addr_d = addr_sh_q[1];
                nxt_cnt_d  = dly_sh_q[2];
            end
            2'd3: begin
                sel_len_d  = len_sh_q[2];
                sel_addr_d = addr_sh_q[2];
                nxt_cnt_d  = dly_sh_q[0];
            end
            default: begin
                sel_len_d  = len_sh_q[0];
                sel_addr_d = addr_sh_q[0];
                nxt_cnt_d  = dly_sh_q[1];
            end
        endcase

        if (seg_q == LP_SEG_LAST) begin
            nxt_seg_d = LP_SEG_FIRST;
        end else begin
            nxt_seg_d = seg_q + 2'd1;
        end

`ifdef AWG_SEQ_LOOP_EN
        // a pass that never read anything must not spin forever
        if ((state_q == ST_PLAY) || played_q) begin
            wrap_ok_d = 1'b1;
        end else begin
            wrap_ok_d = 1'b0;
        end
`else
        wrap_ok_d = 1'b0;
`endif

        // segment ends on its last read, or straight out of DELAY when empty
        if ((state_q == ST_DELAY) && (cnt_q == LP_ZERO) && (sel_len_d == LP_ZERO)) begin
            seg_end_d = 1'b1;
        end else if ((state_q == ST_PLAY) && (rem_q == LP_ONE)) begin
            seg_end_d = 1'b1;
        end else begin
            seg_end_d = 1'b0;
        end

        if (seg_end_d && (seg_q == LP_SEG_LAST) && !wrap_ok_d) begin
            finish_d = 1'b1;
        end else begin
            finish_d = 1'b0;
        end
    end

    // Sequencer FSM, shadow capture and output registers
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q   <= ST_IDLE;
            seg_q     <= LP_SEG_NONE;
            cnt_q     <= LP_ZERO;
            rem_q     <= LP_ZERO;
            addr_q    <= LP_ZERO;
            fin_q     <= 1'b0;
`ifdef AWG_SEQ_LOOP_EN
            played_q  <= 1'b0;
`endif
            for (int i = 0; i < 3; i++) begin
                dly_sh_q[i]  <= LP_ZERO;
                len_sh_q[i]  <= LP_ZERO;
                addr_sh_q[i] <= LP_ZERO;
            end
            rd_en_q   <= 1'b0;
            rd_addr_q <= LP_ZERO;
            seg_o_q   <= LP_SEG_NONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (I_stop) begin
            // abort wins over everything, shadows are kept as they are
            state_q   <= ST_IDLE;
            seg_q     <= LP_SEG_NONE;
            cnt_q     <= LP_ZERO;
            rem_q     <= LP_ZERO;
            fin_q     <= 1'b0;
            rd_en_q   <= 1'b0;
            seg_o_q   <= LP_SEG_NONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // outputs show what the FSM was doing in the cycle just ended
            rd_en_q <= (state_q == ST_PLAY);
            if (state_q == ST_PLAY) begin
                rd_addr_q <= addr_q;
            end else begin
                rd_addr_q <= rd_addr_q;
            end
            seg_o_q <= seg_q;
            busy_q  <= (state_q != ST_IDLE);
            done_q  <= fin_q;
            fin_q   <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (I_trig) begin
                        dly_sh_q[0]  <= I_delay1;
                        dly_sh_q[1]  <= I_delay2;
                        dly_sh_q[2]  <= I_delay3;
                        len_sh_q[0]  <= I_len1;
                        len_sh_q[1]  <= I_len2;
                        len_sh_q[2]  <= I_len3;
                        addr_sh_q[0] <= I_addr1;
                        addr_sh_q[1] <= I_addr2;
                        addr_sh_q[2] <= I_addr3;
                        state_q      <= ST_DELAY;
                        seg_q        <= LP_SEG_FIRST;
                        cnt_q        <= I_delay1;
`ifdef AWG_SEQ_LOOP_EN
                        played_q     <= 1'b0;
`endif
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DELAY: begin
                    if (cnt_q != LP_ZERO) begin
                        cnt_q <= cnt_q - LP_ONE;
                    end else if (sel_len_d != LP_ZERO) begin
                        state_q <= ST_PLAY;
                        addr_q  <= sel_addr_d;
                        rem_q   <= sel_len_d;
`ifdef AWG_SEQ_LOOP_EN
                        played_q <= 1'b1;
`endif
                    end else begin
                        // empty segment: handled by the segment-end step below
                        state_q <= ST_DELAY;
                    end
                end
                ST_PLAY: begin
                    addr_q <= addr_q + LP_ONE;
                    rem_q  <= rem_q - LP_ONE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    seg_q   <= LP_SEG_NONE;
                end
            endcase

            // leaving a segment: next segment's DELAY, wrap, or finish
            if (seg_end_d) begin
                if (finish_d) begin
                    state_q <= ST_IDLE;
                    seg_q   <= LP_SEG_NONE;
                    fin_q   <= 1'b1;
                end else begin
                    state_q <= ST_DELAY;
                    seg_q   <= nxt_seg_d;
                    cnt_q   <= nxt_cnt_d;
`ifdef AWG_SEQ_LOOP_EN
                    if (seg_q == LP_SEG_LAST) begin
                        played_q <= 1'b0;
                    end else begin
                        played_q <= played_q;
                    end
`endif
                end
            end else begin
                fin_q <= 1'b0;
            end
        end
    end

    assign O_rd_en   = rd_en_q;
    assign O_rd_addr = rd_addr_q;
    assign O_seg     = seg_o_q;
    assign O_busy    = busy_q;
    assign O_done    = done_q;

endmodule

// File: tb/tb_awg_seg_sequencer.sv
// Testbench for awg_seg_sequencer: directed and randomized segment tables
// checked cycle by cycle against a timeline model built from the segment
// timing rules (wait DELAY, LEN reads, gaps, done pulse).
module tb_awg_seg_sequencer;

    localparam int W    = 24;
    localparam int MAXC = 256;
`ifdef AWG_SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         trig = 1'b0;
    logic         stop = 1'b0;
    logic [W-1:0] delay1 = '0, delay2 = '0, delay3 = '0;
    logic [W-1:0] len1 = '0, len2 = '0, len3 = '0;
    logic [W-1:0] addr1 = '0, addr2 = '0, addr3 = '0;
    logic         rd_en;
    logic [W-1:0] rd_addr;
    logic [1:0]   seg;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    // segment table for the next run
    int           m_dly [3];
    int           m_len [3];
    logic [W-1:0] m_adr [3];

    // expected per-cycle outputs, cycle 0 = cycle right after the trigger edge
    bit           e_rd   [MAXC];
    logic [W-1:0] e_addr [MAXC];
    int           e_seg  [MAXC];
    bit           e_busy [MAXC];
    bit           e_done [MAXC];
    int           e_fin;

    awg_seg_sequencer #(.P_W(W), .P_NSEG(3)) dut (
        .I_clk(clk), .I_rst(rst), .I_trig(trig), .I_stop(stop),
        .I_delay1(delay1), .I_delay2(delay2), .I_delay3(delay3),
        .I_len1(len1), .I_len2(len2), .I_len3(len3),
        .I_addr1(addr1), .I_addr2(addr2), .I_addr3(addr3),
        .O_rd_en(rd_en), .O_rd_addr(rd_addr), .O_seg(seg),
        .O_busy(busy), .O_done(done)
    );

    always #5 clk = ~clk;

    // Timeline model: segment s starts waiting at cycle c; its reads land at
    // c+D+2 .. c+D+1+L and the next segment starts waiting at c+D+1+L.
    // After the final segment ends at cycle f, done pulses at f+1 and busy
    // covers cycles 1..f.
    task automatic build_model();
        int  c;
        int  s;
        bit  played;
        for (int k = 0; k < MAXC; k++) begin
            e_rd[k] = 1'b0; e_addr[k] = '0; e_seg[k] = 0; e_busy[k] = 1'b0; e_done[k] = 1'b0;
        end
        c = 0; s = 0; played = 1'b0; e_fin = -1;
        while (c < MAXC) begin
            for (int n = 0; n < m_len[s]; n++) begin
                int r;
                r = c + m_dly[s] + 2 + n;
                if (r < MAXC) begin
                    e_rd[r]   = 1'b1;
                    e_addr[r] = m_adr[s] + W'(n);
                    e_seg[r]  = s + 1;
                end
            end
            if (m_len[s] > 0) played = 1'b1;
            c = c + m_dly[s] + 1 + m_len[s];
            if (s == 2) begin
                if (LOOP && played) begin
                    s = 0; played = 1'b0;
                end else begin
                    e_fin = c;
                    break;
                end
            end else begin
                s++;
            end
        end
        for (int k = 1; k < MAXC; k++) e_busy[k] = (e_fin < 0) || (k <= e_fin);
        if (e_fin >= 0 && e_fin + 1 < MAXC) e_done[e_fin + 1] = 1'b1;
    endtask

    task automatic drive_fields();
        delay1 = W'(m_dly[0]); delay2 = W'(m_dly[1]); delay3 = W'(m_dly[2]);
        len1   = W'(m_len[0]); len2   = W'(m_len[1]); len3   = W'(m_len[2]);
        addr1  = m_adr[0];     addr2  = m_adr[1];     addr3  = m_adr[2];
    endtask

    task automatic scramble_fields();
        delay1 = W'($urandom); delay2 = W'($urandom); delay3 = W'($urandom);
        len1   = W'($urandom); len2   = W'($urandom); len3   = W'($urandom);
        addr1  = W'($urandom); addr2  = W'($urandom); addr3  = W'($urandom);
    endtask

    task automatic set_vector(input int v);
        case (v)
            0: begin
                m_dly = '{2, 0, 1}; m_len = '{3, 2, 1};
                m_adr = '{24'h000100, 24'h000200, 24'h000300};
            end
            1: begin
                m_dly = '{2, 0, 1}; m_len = '{3, 0, 1};
                m_adr = '{24'h000100, 24'h000200, 24'h000300};
            end
            2: begin
                m_dly = '{1, 0, 0}; m_len = '{4, 0, 1};
                m_adr = '{24'hFFFFFE, 24'h000050, 24'h000010};
            end
            3: begin
                m_dly = '{3, 1, 2}; m_len = '{0, 0, 0};
                m_adr = '{24'h000111, 24'h000222, 24'h000333};
            end
            default: begin
                for (int i = 0; i < 3; i++) begin
                    m_dly[i] = int'($urandom_range(0, 4));
                    m_len[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 5));
                    m_adr[i] = ($urandom_range(0, 3) == 0) ? (24'hFFFFFF - W'($urandom_range(0, 3)))
                                                           : W'($urandom);
                end
            end
        endcase
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (rd_en   !== 1'b0)  begin bad++; $display("FAIL reset rd_en got=%0b exp=0", rd_en); end
        total++; if (rd_addr !== 24'h0) begin bad++; $display("FAIL reset rd_addr got=%06h exp=000000", rd_addr); end
        total++; if (seg     !== 2'd0)  begin bad++; $display("FAIL reset seg got=%0d exp=0", seg); end
        total++; if (busy    !== 1'b0)  begin bad++; $display("FAIL reset busy got=%0b exp=0", busy); end
        total++; if (done    !== 1'b0)  begin bad++; $display("FAIL reset done got=%0b exp=0", done); end
        rst = 1'b0;
    endtask

    // directed tables (plain, skipped seg2, address wrap, all empty) then random ones
    task automatic test_sequences();
        int win;
        for (int v = 0; v < 20; v++) begin
            set_vector(v);
            build_model();
            @(negedge clk);
            drive_fields();
            trig = 1'b1;
            @(posedge clk); #1;
            trig = 1'b0;
            scramble_fields();
            win = (e_fin >= 0) ? e_fin + 3 : 120;
            for (int k = 0; k < win; k++) begin
                if (k > 0) begin @(posedge clk); #1; end
                total++;
                if (rd_en !== e_rd[k]) begin
                    bad++; $display("FAIL seq%0d rd_en cyc%0d got=%0b exp=%0b", v, k, rd_en, e_rd[k]);
                end
                if (e_rd[k]) begin
                    total++;
                    if (rd_addr !== e_addr[k]) begin
                        bad++; $display("FAIL seq%0d rd_addr cyc%0d got=%06h exp=%06h", v, k, rd_addr, e_addr[k]);
                    end
                    total++;
                    if (seg !== 2'(e_seg[k])) begin
                        bad++; $display("FAIL seq%0d seg cyc%0d got=%0d exp=%0d", v, k, seg, e_seg[k]);
                    end
                end
                total++;
                if (busy !== e_busy[k]) begin
                    bad++; $display("FAIL seq%0d busy cyc%0d got=%0b exp=%0b", v, k, busy, e_busy[k]);
                end
                total++;
                if (done !== e_done[k]) begin
                    bad++; $display("FAIL seq%0d done cyc%0d got=%0b exp=%0b", v, k, done, e_done[k]);
                end
            end
            @(negedge clk); stop = 1'b1;
            @(negedge clk); stop = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        m_dly = '{1, 0, 0}; m_len = '{20, 0, 0};
        m_adr = '{24'h000800, 24'h0, 24'h0};
        @(negedge clk);
        drive_fields();
        trig = 1'b1;
        @(posedge clk); #1;
        trig = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        total++; if (rd_en !== 1'b1) begin bad++; $display("FAIL arst pre rd_en got=%0b exp=1", rd_en); end
        total++; if (rd_addr !== 24'h000803) begin bad++; $display("FAIL arst pre rd_addr got=%06h exp=000803", rd_addr); end
        #2 rst = 1'b1;
        #1;
        total++; if (rd_en   !== 1'b0)  begin bad++; $display("FAIL arst rd_en got=%0b exp=0", rd_en); end
        total++; if (rd_addr !== 24'h0) begin bad++; $display("FAIL arst rd_addr got=%06h exp=000000", rd_addr); end
        total++; if (seg     !== 2'd0)  begin bad++; $display("FAIL arst seg got=%0d exp=0", seg); end
        total++; if (busy    !== 1'b0)  begin bad++; $display("FAIL arst busy got=%0b exp=0", busy); end
        total++; if (done    !== 1'b0)  begin bad++; $display("FAIL arst done got=%0b exp=0", done); end
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst idle busy cyc%0d got=%0b exp=0", k, busy); end
        end
    endtask

    task automatic test_stop();
        set_vector(0);
        @(negedge clk);
        drive_fields();
        trig = 1'b1;
        @(posedge clk); #1;
        trig = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        total++; if (rd_en !== 1'b1) begin bad++; $display("FAIL stop pre rd_en got=%0b exp=1", rd_en); end
        total++; if (rd_addr !== 24'h000200) begin bad++; $display("FAIL stop pre rd_addr got=%06h exp=000200", rd_addr); end
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL stop rd_en got=%0b exp=0", rd_en); end
        total++; if (busy  !== 1'b0) begin bad++; $display("FAIL stop busy got=%0b exp=0", busy); end
        total++; if (seg   !== 2'd0) begin bad++; $display("FAIL stop seg got=%0d exp=0", seg); end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            total++; if (done !== 1'b0) begin bad++; $display("FAIL stop done cyc%0d got=%0b exp=0", k, done); end
            total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL stop idle rd_en cyc%0d got=%0b exp=0", k, rd_en); end
        end
        // trigger and stop together: must stay idle
        trig = 1'b1; stop = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL stoptrig busy cyc%0d got=%0b exp=0", k, busy); end
            total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL stoptrig rd_en cyc%0d got=%0b exp=0", k, rd_en); end
        end
        trig = 1'b0; stop = 1'b0;
        repeat (2) @(negedge clk);
    endtask

`ifndef AWG_SEQ_LOOP_EN
    // level trigger held high: a new pass starts the cycle after each finish
    task automatic test_back_to_back();
        int period;
        m_dly = '{1, 0, 0}; m_len = '{2, 0, 0};
        m_adr = '{24'h000040, 24'h0, 24'h0};
        build_model();
        period = e_fin + 1;
        @(negedge clk);
        drive_fields();
        trig = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 3 * period; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            total++;
            if (rd_en !== e_rd[k % period]) begin
                bad++; $display("FAIL b2b rd_en cyc%0d got=%0b exp=%0b", k, rd_en, e_rd[k % period]);
            end
            if (e_rd[k % period]) begin
                total++;
                if (rd_addr !== e_addr[k % period]) begin
                    bad++; $display("FAIL b2b rd_addr cyc%0d got=%06h exp=%06h", k, rd_addr, e_addr[k % period]);
                end
            end
            total++;
            if (done !== ((k > 0) && (k % period == 0))) begin
                bad++; $display("FAIL b2b done cyc%0d got=%0b exp=%0b", k, done, (k > 0) && (k % period == 0));
            end
        end
        trig = 1'b0;
        repeat (period + 3) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_sequences();
        test_async_reset();
        test_stop();
`ifndef AWG_SEQ_LOOP_EN
        test_back_to_back();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation time limit");
    end

endmodule
